// File: rtl/nmr_voter_pkg.sv
// ---------------------------------------------------------------------------
// nmr_voter_pkg
// Shared definitions for the N-modular-redundant fault voter.
//   NO_WINNER       winner_idx value reported when no majority exists
//   MAX_LANES       widest lane count the helpers are sized for
//   CONSEC_W        width of the per-lane consecutive-disagreement counter
//   popcount_lanes  number of set bits in a lane mask
//   lanes_legal     elaboration-time legality check for the LANES parameter
// ---------------------------------------------------------------------------
package nmr_voter_pkg;

  localparam logic [2:0] NO_WINNER = 3'b111;
  localparam int         MAX_LANES = 7;
  localparam int         CONSEC_W  = 4;

  function automatic logic [3:0] popcount_lanes(input logic [MAX_LANES-1:0] mask);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'b000, mask[i]};
    end
    return c;
  endfunction

  function automatic bit lanes_legal(input int n);
    return (n >= 3) && (n <= MAX_LANES) && ((n % 2) == 1);
  endfunction

endpackage

// File: rtl/nmr_lane_monitor.sv
// ---------------------------------------------------------------------------
// nmr_lane_monitor
// Per-lane fault bookkeeping: consecutive-disagreement counter, quarantine
// flag and saturating lifetime disagreement total.
//   clk, reset     clock and synchronous active-high reset
//   i_active       lane currently takes part in votes
//   i_vote_ok      a valid vote reached a majority this cycle
//   i_disagree     this lane differed from the voted value
//   i_grant_quar   top-level arbitration admits this lane to quarantine
//   i_clr          release quarantine and zero the consecutive counter
//   o_quar         quarantine flag (registered)
//   o_qualify      this edge would bring consec to the threshold
//   o_err_cnt      saturating disagreement total (registered)
// ---------------------------------------------------------------------------
module nmr_lane_monitor
  import nmr_voter_pkg::*;
#(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_active,
  input  logic             i_vote_ok,
  input  logic             i_disagree,
  input  logic             i_grant_quar,
  input  logic             i_clr,
  output logic             o_quar,
  output logic             o_qualify,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [CONSEC_W-1:0] THRESH    = CONSEC_W'(FAULT_THRESH);
  localparam logic [CONSEC_W-1:0] THRESH_M1 = CONSEC_W'(FAULT_THRESH - 1);

  logic [CONSEC_W-1:0] r_consec;
  logic                r_quar;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                w_hit;

  // A counted disagreement only exists for an active lane on a majority vote.
  assign w_hit = i_active && i_vote_ok && i_disagree;

  // Qualifies when this disagreement lands consec on the threshold. A lane
  // refused by the floor sits saturated at the threshold, so it keeps
  // re-qualifying on each later disagreement.
  assign o_qualify = w_hit && (r_consec >= THRESH_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_consec <= '0;
    end else if (i_clr) begin
      r_consec <= '0;
    end else if (i_active && i_vote_ok) begin
      if (i_disagree) begin
        if (r_consec < THRESH) begin
          r_consec <= r_consec + CONSEC_W'(1);
        end
      end else begin
        r_consec <= '0;
      end
    end
  end

  // clr has priority so a release overrides a quarantine forming that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quar <= 1'b0;
    end else if (i_clr) begin
      r_quar <= 1'b0;
    end else if (i_grant_quar) begin
      r_quar <= 1'b1;
    end
  end

  // Lifetime totals survive clr; only reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_hit && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign o_quar    = r_quar;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/nmr_fault_voter.sv
// ---------------------------------------------------------------------------
// nmr_fault_voter
// Registered N-modular-redundant voter with per-lane fault tracking and
// quarantine. One pipeline stage between replicated ALUs and write-back.
//   clk, reset      clock and synchronous active-high reset
//   in_valid        lane_results valid this cycle
//   lane_results    lane i at [i*WIDTH +: WIDTH]
//   clr_quarantine  release all quarantines, zero consecutive counters
//   out_valid       registered in_valid
//   voted_result    voted value (lowest active lane when no majority)
//   vote_ok         majority reached
//   winner_idx      winning lane, NO_WINNER when no majority
//   lane_disagree   active lanes that differed from the voted value
//   lane_quar       quarantine mask, 1 = excluded
//   lane_err_cnt    per-lane saturating disagreement totals
//   nomaj_cnt       saturating count of votes without majority
//   degraded        exactly three lanes remain active
// ---------------------------------------------------------------------------
module nmr_fault_voter
  import nmr_voter_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int LANES        = 5,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] lane_results,
  input  logic                   clr_quarantine,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       voted_result,
  output logic                   vote_ok,
  output logic [2:0]             winner_idx,
  output logic [LANES-1:0]       lane_disagree,
  output logic [LANES-1:0]       lane_quar,
  output logic [LANES*CNT_W-1:0] lane_err_cnt,
  output logic [CNT_W-1:0]       nomaj_cnt,
  output logic                   degraded
);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("nmr_fault_voter: LANES must be odd and within 3..7");
  end
  if ((FAULT_THRESH < 1) || (FAULT_THRESH > 15)) begin : g_bad_thresh
    $error("nmr_fault_voter: FAULT_THRESH must be within 1..15");
  end

  logic [WIDTH-1:0]     w_lane [LANES];
  logic [3:0]           w_count [LANES];
  logic [LANES-1:0]     w_active;
  logic [MAX_LANES-1:0] w_act_mask;
  logic [3:0]           w_num_active;
  logic [3:0]           w_thresh;
  logic                 w_vote_ok;
  logic [2:0]           w_win_idx;
  logic [WIDTH-1:0]     w_win_val;
  logic [WIDTH-1:0]     w_low_active;
  logic [WIDTH-1:0]     w_voted;
  logic [LANES-1:0]     w_disagree;
  logic                 w_vote_event;
  logic [LANES-1:0]     w_qualify;
  logic [LANES-1:0]     w_grant;
  logic [3:0]           w_budget;
  logic [3:0]           w_granted;
  logic [LANES-1:0]     w_next_quar;
  logic [MAX_LANES-1:0] w_next_act;
  logic                 w_next_degraded;
  logic [LANES-1:0]     w_quar;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_voted;
  logic                 r_vote_ok;
  logic [2:0]           r_winner;
  logic [LANES-1:0]     r_disagree;
  logic [CNT_W-1:0]     r_nomaj;
  logic                 r_degraded;

  for (genvar g = 0; g < LANES; g++) begin : g_unpack
    assign w_lane[g] = lane_results[g*WIDTH +: WIDTH];
  end

  assign w_active = ~w_quar;

  // Majority search: each active lane counts its active peers (itself
  // included) with an identical result. The descending scan leaves the
  // lowest qualifying index, and separately the lowest active lane, as the
  // last write.
  always_comb begin
    w_act_mask               = '0;
    w_act_mask[LANES-1:0]    = w_active;
    w_num_active             = popcount_lanes(w_act_mask);
    w_thresh                 = (w_num_active >> 1) + 4'd1;
    w_vote_ok                = 1'b0;
    w_win_idx                = NO_WINNER;
    w_win_val                = w_lane[0];
    w_low_active             = w_lane[0];
    for (int i = 0; i < LANES; i++) begin
      w_count[i] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (w_active[j] && (w_lane[j] == w_lane[i])) begin
          w_count[i] = w_count[i] + 4'd1;
        end
      end
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_low_active = w_lane[i];
        if (w_count[i] >= w_thresh) begin
          w_vote_ok = 1'b1;
          w_win_idx = 3'(i);
          w_win_val = w_lane[i];
        end
      end
    end
    w_voted = w_vote_ok ? w_win_val : w_low_active;
    for (int i = 0; i < LANES; i++) begin
      w_disagree[i] = w_vote_ok && w_active[i] && (w_lane[i] != w_voted);
    end
  end

  assign w_vote_event = in_valid && w_vote_ok;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nmr_lane_monitor #(
      .FAULT_THRESH (FAULT_THRESH),
      .CNT_W        (CNT_W)
    ) u_mon (
      .clk          (clk),
      .reset        (reset),
      .i_active     (w_active[g]),
      .i_vote_ok    (w_vote_event),
      .i_disagree   (w_disagree[g]),
      .i_grant_quar (w_grant[g]),
      .i_clr        (clr_quarantine),
      .o_quar       (w_quar[g]),
      .o_qualify    (w_qualify[g]),
      .o_err_cnt    (lane_err_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Floor arbitration: only (active - 3) lanes may leave on one edge, and
  // qualifying lanes are admitted lowest index first. The guard on the
  // budget keeps it sane even if the mask ever held fewer than three lanes.
  always_comb begin
    w_budget  = (w_num_active > 4'd3) ? (w_num_active - 4'd3) : 4'd0;
    w_granted = '0;
    w_grant   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_qualify[i] && (w_granted < w_budget)) begin
        w_grant[i] = 1'b1;
        w_granted  = w_granted + 4'd1;
      end
    end
  end

  // Mirror of the mask the monitors will hold after this edge, so that
  // degraded is registered in step with lane_quar.
  always_comb begin
    w_next_quar            = clr_quarantine ? '0 : (w_quar | w_grant);
    w_next_act             = '0;
    w_next_act[LANES-1:0]  = ~w_next_quar;
    w_next_degraded        = (popcount_lanes(w_next_act) == 4'd3);
  end

  // Vote outputs only move on an in_valid cycle; in between they hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_voted     <= '0;
      r_vote_ok   <= 1'b0;
      r_winner    <= NO_WINNER;
      r_disagree  <= '0;
      r_nomaj     <= '0;
      r_degraded  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_degraded  <= w_next_degraded;
      if (in_valid) begin
        r_voted    <= w_voted;
        r_vote_ok  <= w_vote_ok;
        r_winner   <= w_win_idx;
        r_disagree <= w_disagree;
        if (!w_vote_ok && (r_nomaj != '1)) begin
          r_nomaj <= r_nomaj + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign voted_result  = r_voted;
  assign vote_ok       = r_vote_ok;
  assign winner_idx    = r_winner;
  assign lane_disagree = r_disagree;
  assign lane_quar     = w_quar;
  assign nomaj_cnt     = r_nomaj;
  assign degraded      = r_degraded;

endmodule

// File: tb/tb_nmr_fault_voter.sv
// ---------------------------------------------------------------------------
// tb_nmr_fault_voter
// Directed bench for nmr_fault_voter (WIDTH=64, LANES=5, FAULT_THRESH=4,
// CNT_W=8). A table of per-cycle vectors carries stimulus plus hand-derived
// expected outputs; a few hand-written sequences cover reset during a vote
// and counter saturation.
// ---------------------------------------------------------------------------
module tb_nmr_fault_voter;

  localparam int WIDTH = 64;
  localparam int LANES = 5;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] lane_results;
  logic                   clr_quarantine;
  logic                   out_valid;
  logic [WIDTH-1:0]       voted_result;
  logic                   vote_ok;
  logic [2:0]             winner_idx;
  logic [LANES-1:0]       lane_disagree;
  logic [LANES-1:0]       lane_quar;
  logic [LANES*CNT_W-1:0] lane_err_cnt;
  logic [CNT_W-1:0]       nomaj_cnt;
  logic                   degraded;

  nmr_fault_voter #(
    .WIDTH        (WIDTH),
    .LANES        (LANES),
    .FAULT_THRESH (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .lane_results   (lane_results),
    .clr_quarantine (clr_quarantine),
    .out_valid      (out_valid),
    .voted_result   (voted_result),
    .vote_ok        (vote_ok),
    .winner_idx     (winner_idx),
    .lane_disagree  (lane_disagree),
    .lane_quar      (lane_quar),
    .lane_err_cnt   (lane_err_cnt),
    .nomaj_cnt      (nomaj_cnt),
    .degraded       (degraded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                   rst;
    logic                   vld;
    logic                   clr;
    logic [LANES*WIDTH-1:0] lanes;
    logic                   eValid;
    logic                   eOk;
    logic [2:0]             eWin;
    logic [WIDTH-1:0]       eVoted;
    logic [LANES-1:0]       eDis;
    logic [LANES-1:0]       eQuar;
    logic                   eDeg;
    logic [CNT_W-1:0]       eNomaj;
    logic [LANES*CNT_W-1:0] eErr;
  } vec_t;

  vec_t vecs[$];
  int   nVectors;
  int   nMiscompares;

  localparam logic [63:0] DEAD = 64'hDEAD;
  localparam logic [63:0] G    = 64'h1234;
  localparam logic [63:0] BAD  = 64'hBAD;
  localparam logic [63:0] C    = 64'hC0DE;

  function automatic logic [LANES*WIDTH-1:0] packLanes(input logic [63:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic addVec(input logic rst, vld, clr, input logic [LANES*WIDTH-1:0] lanes,
                        input logic eValid, eOk, input logic [2:0] eWin,
                        input logic [WIDTH-1:0] eVoted, input logic [LANES-1:0] eDis, eQuar,
                        input logic eDeg, input logic [CNT_W-1:0] eNomaj,
                        input logic [LANES*CNT_W-1:0] eErr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.clr = clr; v.lanes = lanes;
    v.eValid = eValid; v.eOk = eOk; v.eWin = eWin; v.eVoted = eVoted;
    v.eDis = eDis; v.eQuar = eQuar; v.eDeg = eDeg; v.eNomaj = eNomaj; v.eErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    if (got !== want) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Drive one cycle of stimulus, then sample #1 after the edge.
  task automatic applyStimulus(input logic rst, vld, clr, input logic [LANES*WIDTH-1:0] lanes);
    reset          = rst;
    in_valid       = vld;
    clr_quarantine = clr;
    lane_results   = lanes;
    @(posedge clk);
    #1;
    nVectors++;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp($sformatf("v%0d.out_valid", idx),     64'(out_valid),     64'(v.eValid));
    cmp($sformatf("v%0d.vote_ok", idx),       64'(vote_ok),       64'(v.eOk));
    cmp($sformatf("v%0d.winner_idx", idx),    64'(winner_idx),    64'(v.eWin));
    cmp($sformatf("v%0d.voted_result", idx),  voted_result,       v.eVoted);
    cmp($sformatf("v%0d.lane_disagree", idx), 64'(lane_disagree), 64'(v.eDis));
    cmp($sformatf("v%0d.lane_quar", idx),     64'(lane_quar),     64'(v.eQuar));
    cmp($sformatf("v%0d.degraded", idx),      64'(degraded),      64'(v.eDeg));
    cmp($sformatf("v%0d.nomaj_cnt", idx),     64'(nomaj_cnt),     64'(v.eNomaj));
    cmp($sformatf("v%0d.lane_err_cnt", idx),  64'(lane_err_cnt),  64'(v.eErr));
  endtask

  initial begin
    nVectors       = 0;
    nMiscompares   = 0;
    reset          = 1'b1;
    in_valid       = 1'b0;
    clr_quarantine = 1'b0;
    lane_results   = '0;

    // err vector literal bytes read lane4..lane0, left to right.
    addVec(1,0,0, '0, 0,0,3'd7, 0, 5'b0, 5'b0, 0, 0, 40'h0);

    // All lanes agree.
    addVec(0,1,0, packLanes(DEAD,DEAD,DEAD,DEAD,DEAD), 1,1,3'd0, DEAD, 5'b0, 5'b0, 0, 0, 40'h0);
    // Idle cycle: out_valid drops, everything else holds.
    addVec(0,0,0, '0, 0,1,3'd0, DEAD, 5'b0, 5'b0, 0, 0, 40'h0);

    // Lane 2 persistently wrong: quarantined on the 4th disagreement.
    addVec(0,1,0, packLanes(G,G,BAD,G,G), 1,1,3'd0, G, 5'b00100, 5'b00000, 0, 0, 40'h0000010000);
    addVec(0,1,0, packLanes(G,G,BAD,G,G), 1,1,3'd0, G, 5'b00100, 5'b00000, 0, 0, 40'h0000020000);
    addVec(0,1,0, packLanes(G,G,BAD,G,G), 1,1,3'd0, G, 5'b00100, 5'b00000, 0, 0, 40'h0000030000);
    addVec(0,1,0, packLanes(G,G,BAD,G,G), 1,1,3'd0, G, 5'b00100, 5'b00100, 0, 0, 40'h0000040000);
    // Quarantined lane is neither compared nor counted.
    addVec(0,1,0, packLanes(G,G,BAD,G,G), 1,1,3'd0, G, 5'b00000, 5'b00100, 0, 0, 40'h0000040000);
    // Lane 2 would make three G votes, but only lanes 0,1 count: 2 < T=3.
    addVec(0,1,0, packLanes(G,G,G,64'h7,64'h8), 1,0,3'd7, G, 5'b00000, 5'b00100, 0, 1, 40'h0000040000);
    // Three of four active agree: T=3 met.
    addVec(0,1,0, packLanes(G,64'h7,BAD,G,G), 1,1,3'd0, G, 5'b00010, 5'b00100, 0, 1, 40'h0000040100);

    addVec(1,0,0, '0, 0,0,3'd7, 0, 5'b0, 5'b0, 0, 0, 40'h0);

    // Lanes 0,1 wrong together: both admitted on the same edge, floor reached.
    addVec(0,1,0, packLanes(64'h1,64'h2,C,C,C), 1,1,3'd2, C, 5'b00011, 5'b00000, 0, 0, 40'h0000000101);
    addVec(0,1,0, packLanes(64'h1,64'h2,C,C,C), 1,1,3'd2, C, 5'b00011, 5'b00000, 0, 0, 40'h0000000202);
    addVec(0,1,0, packLanes(64'h1,64'h2,C,C,C), 1,1,3'd2, C, 5'b00011, 5'b00000, 0, 0, 40'h0000000303);
    addVec(0,1,0, packLanes(64'h1,64'h2,C,C,C), 1,1,3'd2, C, 5'b00011, 5'b00011, 1, 0, 40'h0000000404);
    // Lane 2 then goes bad: refused by the floor each time, lane 3 wins.
    for (int k = 1; k <= 5; k++) begin
      addVec(0,1,0, packLanes(64'h77,64'h77,64'h5,C,C), 1,1,3'd3, C, 5'b00100, 5'b00011, 1, 0,
             {8'h00, 8'h00, 8'(k), 8'h04, 8'h04});
    end

    addVec(1,0,0, '0, 0,0,3'd7, 0, 5'b0, 5'b0, 0, 0, 40'h0);

    // No-majority vote leaves lane 4's consecutive count at 3, so the next
    // disagreement quarantines it.
    addVec(0,1,0, packLanes(C,C,C,C,64'h6), 1,1,3'd0, C, 5'b10000, 5'b00000, 0, 0, 40'h0100000000);
    addVec(0,1,0, packLanes(C,C,C,C,64'h6), 1,1,3'd0, C, 5'b10000, 5'b00000, 0, 0, 40'h0200000000);
    addVec(0,1,0, packLanes(C,C,C,C,64'h6), 1,1,3'd0, C, 5'b10000, 5'b00000, 0, 0, 40'h0300000000);
    addVec(0,1,0, packLanes(64'hA,64'hA,64'hB,64'hB,64'hCC), 1,0,3'd7, 64'hA, 5'b00000, 5'b00000, 0, 1, 40'h0300000000);
    addVec(0,1,0, packLanes(C,C,C,C,64'h6), 1,1,3'd0, C, 5'b10000, 5'b10000, 0, 1, 40'h0400000000);

    addVec(1,0,0, '0, 0,0,3'd7, 0, 5'b0, 5'b0, 0, 0, 40'h0);

    // clr on the 4th disagreement: vote uses old mask, quarantine cancelled,
    // consec restarts so a 5th disagreement does not quarantine.
    addVec(0,1,0, packLanes(C,C,64'h5,C,C), 1,1,3'd0, C, 5'b00100, 5'b00000, 0, 0, 40'h0000010000);
    addVec(0,1,0, packLanes(C,C,64'h5,C,C), 1,1,3'd0, C, 5'b00100, 5'b00000, 0, 0, 40'h0000020000);
    addVec(0,1,0, packLanes(C,C,64'h5,C,C), 1,1,3'd0, C, 5'b00100, 5'b00000, 0, 0, 40'h0000030000);
    addVec(0,1,1, packLanes(C,C,64'h5,C,C), 1,1,3'd0, C, 5'b00100, 5'b00000, 0, 0, 40'h0000040000);
    addVec(0,1,0, packLanes(C,C,64'h5,C,C), 1,1,3'd0, C, 5'b00100, 5'b00000, 0, 0, 40'h0000050000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].clr, vecs[i].lanes);
      checkOutput(vecs[i], i);
    end

    // Reset arriving the cycle after a vote, with another vote in flight.
    applyStimulus(0, 1, 0, packLanes(DEAD,DEAD,DEAD,DEAD,DEAD));
    cmp("rst.pre_out_valid", 64'(out_valid), 64'd1);
    applyStimulus(1, 1, 0, packLanes(DEAD,DEAD,DEAD,DEAD,DEAD));
    cmp("rst.out_valid",   64'(out_valid),    64'd0);
    cmp("rst.vote_ok",     64'(vote_ok),      64'd0);
    cmp("rst.winner_idx",  64'(winner_idx),   64'd7);
    cmp("rst.lane_err",    64'(lane_err_cnt), 64'd0);
    cmp("rst.lane_quar",   64'(lane_quar),    64'd0);
    cmp("rst.voted",       voted_result,      64'd0);
    applyStimulus(0, 0, 0, '0);
    cmp("rst.post_out_valid", 64'(out_valid), 64'd0);

    // Saturation: degrade to lanes 2..4, then keep lane 2 disagreeing.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, packLanes(64'h1,64'h2,C,C,C));
    end
    for (int k = 0; k < 260; k++) begin
      applyStimulus(0, 1, 0, packLanes(64'h77,64'h77,64'h5,C,C));
    end
    cmp("sat.lane_err", 64'(lane_err_cnt), 64'h0000FF0404);
    cmp("sat.lane_quar", 64'(lane_quar), 64'b00011);
    cmp("sat.degraded", 64'(degraded), 64'd1);
    for (int k = 0; k < 260; k++) begin
      applyStimulus(0, 1, 0, packLanes(64'h77,64'h77,64'h1,64'h2,64'h3));
    end
    cmp("sat.nomaj_cnt", 64'(nomaj_cnt), 64'd255);
    cmp("sat.vote_ok", 64'(vote_ok), 64'd0);
    cmp("sat.winner_idx", 64'(winner_idx), 64'd7);
    cmp("sat.voted_lowest_active", voted_result, 64'h1);
    cmp("sat.lane_err_kept", 64'(lane_err_cnt), 64'h0000FF0404);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
